// File: rtl/pipe_rca_adder_if.sv
// pipe_rca_adder_if -- operand/result bus of the pipelined ripple-carry adder.
//
// Signals:
//   in_valid, in_ready   : operand handshake (producer -> adder)
//   A, B, C_in, sub      : operand set, qualified by in_valid
//   SUM, C_out, ovf      : result, qualified by out_valid
//   out_valid, out_ready : result handshake (adder -> consumer)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A producer holding valid=1 keeps its payload stable until that
// transfer; ready may depend combinationally on the consumer side but never on
// the matching valid.
//
// Modports: master = operand producer / result consumer (the environment),
//           slave  = the adder.

interface pipe_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             sub;
    logic [WIDTH-1:0] SUM;
    logic             C_out;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, A, B, C_in, sub, out_ready,
        input  in_ready, SUM, C_out, ovf, out_valid
    );

    modport slave (
        input  in_valid, A, B, C_in, sub, out_ready,
        output in_ready, SUM, C_out, ovf, out_valid
    );
endinterface

// File: rtl/pipe_rca_adder.sv
// pipe_rca_adder -- pipelined ripple-carry adder/subtractor.
//
// The WIDTH-bit addition is split into STAGES chunks of CW = WIDTH/STAGES bits.
// Stage k adds chunk k and hands its carry to stage k+1 one cycle later, so a
// result takes STAGES cycles and a new operand set can enter every cycle.
// The whole pipeline stalls together whenever a held result is not taken.
//
// Ports:
//   clk   : clock, all state updates on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : pipe_rca_adder_if.slave (operands, result, both handshakes)
//
// Parameters:
//   WIDTH  : operand/sum width (must be a multiple of STAGES)
//   STAGES : number of pipeline stages, STAGES=1 gives a single registered adder

module pipe_rca_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_rca_adder_if.slave   bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers. Each stage carries the full operand words forward
    // so higher chunks are still available to later stages, and the full sum
    // word so lower partial sums travel with their transaction.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] valid_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_d;
    logic              ovf_d;

    // Inputs seen by each stage: the bus for stage 0, the previous stage's
    // registers otherwise.
    logic [WIDTH-1:0]  a_s   [STAGES];
    logic [WIDTH-1:0]  b_s   [STAGES];
    logic [WIDTH-1:0]  sum_s [STAGES];
    logic [STAGES-1:0] c_s;
    logic [STAGES-1:0] v_s;

    logic [CW:0]       chunk;
    logic              adv;

    // Global advance: the pipeline moves whenever the output slot is empty or
    // being drained this cycle.
    assign adv           = !valid_q[LAST] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[LAST];
    assign bus.SUM       = sum_q[LAST];
    assign bus.C_out     = carry_q[LAST];
    assign bus.ovf       = ovf_q;

    always_comb begin
        chunk   = '0;
        carry_d = '0;
        valid_d = '0;
        c_s     = '0;
        v_s     = '0;
        ovf_d   = 1'b0;

        // Subtraction is A + ~B + 1; C_in is ignored in that mode.
        a_s[0]   = bus.A;
        b_s[0]   = bus.sub ? ~bus.B : bus.B;
        sum_s[0] = '0;
        c_s[0]   = bus.sub | bus.C_in;
        v_s[0]   = bus.in_valid;

        for (int k = 1; k < STAGES; k++) begin
            a_s[k]   = a_q[k-1];
            b_s[k]   = b_q[k-1];
            sum_s[k] = sum_q[k-1];
            c_s[k]   = carry_q[k-1];
            v_s[k]   = valid_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, a_s[k][k*CW +: CW]}
                  + {1'b0, b_s[k][k*CW +: CW]}
                  + {{CW{1'b0}}, c_s[k]};
            a_d[k]               = a_s[k];
            b_d[k]               = b_s[k];
            sum_d[k]             = sum_s[k];
            sum_d[k][k*CW +: CW] = chunk[CW-1:0];
            carry_d[k]           = chunk[CW];
            valid_d[k]           = v_s[k];
        end

        // Signed overflow: operands agree in sign, result does not.
        ovf_d = (a_s[LAST][WIDTH-1] == b_s[LAST][WIDTH-1]) &&
                (sum_d[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pipe_rca_adder.sv
// tb_pipe_rca_adder -- directed self-checking bench for pipe_rca_adder
// (WIDTH=16, STAGES=4). Expected values are hand-computed constants.

module tb_pipe_rca_adder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pipe_rca_adder_if #(.WIDTH(16)) bus ();

    pipe_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for one cycle, then wait until its result is due.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic s);
        bus.A        = a;
        bus.B        = b;
        bus.C_in     = cin;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = 16'hAAAA;
        bus.B         = 16'h5555;
        bus.C_in      = 1'b1;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", bus.SUM); end
        checks++; if (bus.C_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", bus.C_out); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();
    endtask

    task automatic test_add();
        send_one(16'h6A5C, 16'h1234, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.SUM !== 16'h7C90) begin errors++; $display("FAIL add_sum: got %h expected 7c90", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b00) begin errors++; $display("FAIL add_flags: got c=%b o=%b expected c=0 o=0", bus.C_out, bus.ovf); end
        idle(2);
        send_one(16'h0001, 16'h0001, 1'b1, 1'b0);
        checks++; if (bus.SUM !== 16'h0003) begin errors++; $display("FAIL add_cin_sum: got %h expected 0003", bus.SUM); end
        idle(2);
    endtask

    task automatic test_carry_ripple();
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL ripple_sum: got %h expected 0000", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b10) begin errors++; $display("FAIL ripple_flags: got c=%b o=%b expected c=1 o=0", bus.C_out, bus.ovf); end
        idle(2);
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checks++; if (bus.SUM !== 16'h8000) begin errors++; $display("FAIL ovf_sum: got %h expected 8000", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags: got c=%b o=%b expected c=0 o=1", bus.C_out, bus.ovf); end
        idle(2);
    endtask

    task automatic test_sub();
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1);
        checks++; if (bus.SUM !== 16'hFFFE) begin errors++; $display("FAIL sub_sum: got %h expected fffe", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b00) begin errors++; $display("FAIL sub_flags: got c=%b o=%b expected c=0 o=0", bus.C_out, bus.ovf); end
        idle(2);
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1);
        checks++; if (bus.SUM !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_sum: got %h expected 7fff", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b11) begin errors++; $display("FAIL sub_ovf_flags: got c=%b o=%b expected c=1 o=1", bus.C_out, bus.ovf); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [17:0] ve [5];   // {C_out, ovf, SUM}
        logic [17:0] exp_q [$];
        logic [17:0] got_v;
        int sent, got, stalled;
        va[0] = 16'h0001; vb[0] = 16'h0002; ve[0] = {2'b00, 16'h0003};
        va[1] = 16'h1111; vb[1] = 16'h2222; ve[1] = {2'b00, 16'h3333};
        va[2] = 16'h8000; vb[2] = 16'h8000; ve[2] = {2'b11, 16'h0000};
        va[3] = 16'h00FF; vb[3] = 16'h0001; ve[3] = {2'b00, 16'h0100};
        va[4] = 16'h4000; vb[4] = 16'h4000; ve[4] = {2'b01, 16'h8000};
        sent = 0; got = 0; stalled = 0;
        bus.C_in = 1'b0;
        bus.sub  = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            bus.in_valid  = (sent < 5);
            bus.A         = (sent < 5) ? va[sent] : 16'h0000;
            bus.B         = (sent < 5) ? vb[sent] : 16'h0000;
            bus.out_ready = !(bus.out_valid && stalled < 3);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stalled++;
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b expected 0", bus.in_ready); end
                got_v = {bus.C_out, bus.ovf, bus.SUM};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_stall_hold: got %h expected no result", got_v); end
                else if (got_v !== exp_q[0]) begin errors++; $display("FAIL b2b_stall_hold: got %h expected %h", got_v, exp_q[0]); end
            end
            if (bus.out_valid && bus.out_ready) begin
                got_v = {bus.C_out, bus.ovf, bus.SUM};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_result: got %h expected no result", got_v); end
                else begin
                    if (got_v !== exp_q[0]) begin errors++; $display("FAIL b2b_result: got %h expected %h", got_v, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ve[sent]);
                sent++;
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got !== 5) begin errors++; $display("FAIL b2b_count: got %0d results expected 5", got); end
        checks++; if (stalled !== 3) begin errors++; $display("FAIL b2b_stall_len: got %0d stall cycles expected 3", stalled); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra: got out_valid=%b expected 0 after drain", bus.out_valid); end
        end
    endtask

    task automatic test_reset_flush();
        bus.out_ready = 1'b1;
        bus.C_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A = 16'h1234; bus.B = 16'h1111; step();
        bus.A = 16'h2222; bus.B = 16'h3333; step();
        bus.A = 16'h7FFF; bus.B = 16'h7FFF; step();
        // Reset edge with a simultaneous operand on the bus.
        rst_n = 1'b0;
        bus.A = 16'hFFFF; bus.B = 16'hFFFF;
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.SUM !== 16'h0000) begin errors++; $display("FAIL flush_sum: got %h expected 0000", bus.SUM); end
        checks++; if ({bus.C_out, bus.ovf} !== 2'b00) begin errors++; $display("FAIL flush_flags: got c=%b o=%b expected 0 0", bus.C_out, bus.ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: got out_valid=%b sum=%h expected no result", bus.out_valid, bus.SUM); end
        end
        send_one(16'h0010, 16'h0020, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.SUM !== 16'h0030) begin errors++; $display("FAIL flush_new_sum: got %h expected 0030", bus.SUM); end
        idle(3);
    endtask

    task automatic test_bubbles();
        logic [5:0] pat;
        logic       exp_v;
        pat           = 6'b010101;   // bit c = in_valid at cycle c
        bus.out_ready = 1'b1;
        bus.C_in      = 1'b0;
        bus.sub       = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (c < 6) ? pat[c] : 1'b0;
            bus.A        = 16'(c);
            bus.B        = 16'h0100;
            #1;
            exp_v = (c >= 4 && c < 10) ? pat[c-4] : 1'b0;
            checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL bubble_valid_c%0d: got %b expected %b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.SUM !== 16'h0100 + 16'(c - 4)) begin errors++; $display("FAIL bubble_sum_c%0d: got %h expected %h", c, bus.SUM, 16'h0100 + 16'(c - 4)); end
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.C_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_back_to_back();
        test_reset_flush();
        test_bubbles();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
